// File: rtl/cc_lives_controller.sv
// Game-state controller fed by the matrix comparator's crash flag: tracks lives,
// freezes play during the post-crash penalty, requests frog respawns and latches game over.
module cc_lives_controller #(
    parameter int LIVES_INIT     = 3,
    parameter int LIVES_WIDTH    = 2,
    parameter int PENALTY_CYCLES = 16,
    parameter int PENALTY_WIDTH  = 5
) (
    input  logic                   CC_LIVESCONTROLLER_CLOCK_50,
    input  logic                   CC_LIVESCONTROLLER_RESET_InHigh,
    input  logic                   CC_LIVESCONTROLLER_crash_In,
    input  logic                   CC_LIVESCONTROLLER_start_InLow,
    output logic [LIVES_WIDTH-1:0] CC_LIVESCONTROLLER_lives_OutBUS,
    output logic                   CC_LIVESCONTROLLER_freeze_OutHigh,
    output logic                   CC_LIVESCONTROLLER_respawn_OutHigh,
    output logic                   CC_LIVESCONTROLLER_gameover_OutHigh,
    output logic [1:0]             CC_LIVESCONTROLLER_state_OutBUS
);

    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        PLAY     = 2'b01,
        HIT      = 2'b10,
        GAMEOVER = 2'b11
    } stateT;

    localparam logic [LIVES_WIDTH-1:0]   livesInit   = LIVES_WIDTH'(LIVES_INIT);
    localparam logic [LIVES_WIDTH-1:0]   livesOne    = LIVES_WIDTH'(1);
    localparam logic [PENALTY_WIDTH-1:0] penaltyLoad = PENALTY_WIDTH'(PENALTY_CYCLES - 1);

    stateT                    state, stateNext;
    logic [LIVES_WIDTH-1:0]   lives, livesNext;
    logic [PENALTY_WIDTH-1:0] penaltyCnt, penaltyCntNext;
    logic                     respawn, respawnNext;
    logic                     crashQ, startQ;
    logic                     hit, press;

    // Rising crash level and falling start level each count as one event.
    assign hit   = CC_LIVESCONTROLLER_crash_In & ~crashQ;
    assign press = ~CC_LIVESCONTROLLER_start_InLow & startQ;

    always_ff @(posedge CC_LIVESCONTROLLER_CLOCK_50) begin
        if (CC_LIVESCONTROLLER_RESET_InHigh) begin
            state      <= IDLE;
            lives      <= livesInit;
            penaltyCnt <= '0;
            respawn    <= 1'b0;
            crashQ     <= 1'b0;
            startQ     <= 1'b1;
        end else begin
            state      <= stateNext;
            lives      <= livesNext;
            penaltyCnt <= penaltyCntNext;
            respawn    <= respawnNext;
            crashQ     <= CC_LIVESCONTROLLER_crash_In;
            startQ     <= CC_LIVESCONTROLLER_start_InLow;
        end
    end

    always_comb begin
        stateNext      = state;
        livesNext      = lives;
        penaltyCntNext = penaltyCnt;
        respawnNext    = 1'b0;
        case (state)
            IDLE: begin
                if (press) begin
                    stateNext   = PLAY;
                    livesNext   = livesInit;
                    respawnNext = 1'b1;
                end
            end
            PLAY: begin
                if (hit) begin
                    if (lives > livesOne) begin
                        stateNext      = HIT;
                        livesNext      = lives - livesOne;
                        penaltyCntNext = penaltyLoad;
                    end else begin
                        stateNext = GAMEOVER;
                        livesNext = '0;
                    end
                end
            end
            HIT: begin
                if (penaltyCnt == '0) begin
                    stateNext   = PLAY;
                    respawnNext = 1'b1;
                end else begin
                    penaltyCntNext = penaltyCnt - 1'b1;
                end
            end
            GAMEOVER: begin
                livesNext = '0;
                if (press) begin
                    stateNext   = PLAY;
                    livesNext   = livesInit;
                    respawnNext = 1'b1;
                end
            end
            default: begin
                stateNext      = IDLE;
                livesNext      = livesInit;
                penaltyCntNext = '0;
            end
        endcase
    end

    assign CC_LIVESCONTROLLER_lives_OutBUS      = lives;
    assign CC_LIVESCONTROLLER_freeze_OutHigh    = (state != PLAY);
    assign CC_LIVESCONTROLLER_respawn_OutHigh   = respawn;
    assign CC_LIVESCONTROLLER_gameover_OutHigh  = (state == GAMEOVER);
    assign CC_LIVESCONTROLLER_state_OutBUS      = state;

endmodule

// File: tb/tb_cc_lives_controller.sv
// Scoreboard bench for cc_lives_controller: each driven cycle queues the outputs
// expected after the next rising edge, and a monitor pops and compares them.
module tb_cc_lives_controller;

    localparam logic [1:0] sIdle = 2'b00;
    localparam logic [1:0] sPlay = 2'b01;
    localparam logic [1:0] sHit  = 2'b10;
    localparam logic [1:0] sOver = 2'b11;

    typedef struct {
        logic [1:0] state;
        logic [1:0] lives;
        logic       freeze;
        logic       respawn;
        logic       gameover;
    } expectT;

    logic       clock = 1'b0;
    logic       reset;
    logic       crash;
    logic       startLow;
    logic [1:0] lives;
    logic       freeze;
    logic       respawn;
    logic       gameover;
    logic [1:0] state;

    expectT expQ[$];
    int     vectors = 0;
    int     miscompares = 0;

    cc_lives_controller dut (
        .CC_LIVESCONTROLLER_CLOCK_50         (clock),
        .CC_LIVESCONTROLLER_RESET_InHigh     (reset),
        .CC_LIVESCONTROLLER_crash_In         (crash),
        .CC_LIVESCONTROLLER_start_InLow      (startLow),
        .CC_LIVESCONTROLLER_lives_OutBUS     (lives),
        .CC_LIVESCONTROLLER_freeze_OutHigh   (freeze),
        .CC_LIVESCONTROLLER_respawn_OutHigh  (respawn),
        .CC_LIVESCONTROLLER_gameover_OutHigh (gameover),
        .CC_LIVESCONTROLLER_state_OutBUS     (state)
    );

    always #10 clock = ~clock;

    task automatic checkOutput(input string tag, input int observed, input int expected);
        vectors++;
        if (observed != expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, wanted %0d at %0t", tag, observed, expected, $time);
        end
    endtask

    // One cycle: drive inputs away from the edge and queue what must appear after it.
    task automatic applyStimulus(input logic rst, input logic cr, input logic stLow,
                                 input logic [1:0] expState, input logic [1:0] expLives,
                                 input logic expRespawn);
        expectT e;
        @(negedge clock);
        reset    = rst;
        crash    = cr;
        startLow = stLow;
        e.state    = expState;
        e.lives    = expLives;
        e.freeze   = (expState != sPlay);
        e.respawn  = expRespawn;
        e.gameover = (expState == sOver);
        expQ.push_back(e);
    endtask

    task automatic holdCycles(input int n, input logic cr, input logic stLow,
                              input logic [1:0] expState, input logic [1:0] expLives);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, cr, stLow, expState, expLives, 1'b0);
    endtask

    always @(posedge clock) begin
        expectT e;
        #1;
        if (expQ.size() > 0) begin
            e = expQ.pop_front();
            checkOutput("state",    int'(state),    int'(e.state));
            checkOutput("lives",    int'(lives),    int'(e.lives));
            checkOutput("freeze",   int'(freeze),   int'(e.freeze));
            checkOutput("respawn",  int'(respawn),  int'(e.respawn));
            checkOutput("gameover", int'(gameover), int'(e.gameover));
        end
    end

    initial begin
        reset    = 1'b1;
        crash    = 1'b0;
        startLow = 1'b1;

        // Reset state, then crash pulses while idle must not touch lives.
        applyStimulus(1'b1, 1'b0, 1'b1, sIdle, 2'd3, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b1, sIdle, 2'd3, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, sIdle, 2'd3, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b1, sIdle, 2'd3, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, sIdle, 2'd3, 1'b0);

        // Start press: one respawn pulse, holding the button does nothing more.
        applyStimulus(1'b0, 1'b0, 1'b0, sPlay, 2'd3, 1'b1);
        holdCycles(2, 1'b0, 1'b0, sPlay, 2'd3);
        holdCycles(2, 1'b0, 1'b1, sPlay, 2'd3);

        // Crash held high for 40 cycles: single decrement, 16-cycle freeze, one respawn.
        applyStimulus(1'b0, 1'b1, 1'b1, sHit, 2'd2, 1'b0);
        holdCycles(15, 1'b1, 1'b1, sHit, 2'd2);
        applyStimulus(1'b0, 1'b1, 1'b1, sPlay, 2'd2, 1'b1);
        holdCycles(23, 1'b1, 1'b1, sPlay, 2'd2);
        holdCycles(2, 1'b0, 1'b1, sPlay, 2'd2);

        // Crash and press together in PLAY: hit wins; crashes and presses in HIT ignored.
        applyStimulus(1'b0, 1'b1, 1'b0, sHit, 2'd1, 1'b0);
        for (int i = 0; i < 15; i++)
            applyStimulus(1'b0, logic'(i % 2), logic'((i % 3) != 0), sHit, 2'd1, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, sPlay, 2'd1, 1'b1);
        holdCycles(2, 1'b0, 1'b1, sPlay, 2'd1);

        // Last life lost: game over latches and holds through further crashes.
        applyStimulus(1'b0, 1'b1, 1'b1, sOver, 2'd0, 1'b0);
        holdCycles(2, 1'b0, 1'b1, sOver, 2'd0);
        applyStimulus(1'b0, 1'b1, 1'b1, sOver, 2'd0, 1'b0);
        holdCycles(2, 1'b0, 1'b1, sOver, 2'd0);

        // Restart from game over.
        applyStimulus(1'b0, 1'b0, 1'b0, sPlay, 2'd3, 1'b1);
        holdCycles(2, 1'b0, 1'b1, sPlay, 2'd3);

        // Reset in the middle of the penalty window, at counter value 7.
        applyStimulus(1'b0, 1'b1, 1'b1, sHit, 2'd2, 1'b0);
        holdCycles(8, 1'b0, 1'b1, sHit, 2'd2);
        applyStimulus(1'b1, 1'b0, 1'b1, sIdle, 2'd3, 1'b0);
        holdCycles(2, 1'b0, 1'b1, sIdle, 2'd3);
        applyStimulus(1'b0, 1'b0, 1'b0, sPlay, 2'd3, 1'b1);
        holdCycles(1, 1'b0, 1'b1, sPlay, 2'd3);

        @(posedge clock);
        #3;
        checkOutput("queueDrain", expQ.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
